// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine.
//
// Accepts one 128-bit state over a valid/ready handshake and substitutes its
// 16 bytes through LANES forward S-boxes, LANES bytes per clock, then holds
// the result until the downstream takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_data byte k = in_data[8k +: 8]
//   out_valid/out_ready output handshake; out_data byte k = S(in_data byte k)
//   busy                high while bytes are being substituted
//
// Also holds the forward AES S-box used by every lane.

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform.
//   data_i  byte to substitute
//   data_o  S(data_i)
module sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0 and maps 0 to 0, as SubBytes requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv    = gf_inv(data_i);
        data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module sub_bytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned GrpW  = 8 * LANES;
    localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
    begin : gen_bad_lanes
        $error("sub_bytes_iter: LANES must be one of 1, 2, 4, 8, 16");
    end

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Working register viewed as STEPS groups of LANES bytes; group c is the
    // slice handled in SUB cycle c.
    logic [STEPS-1:0][GrpW-1:0] data_q, data_d, data_sub;
    logic [GrpW-1:0] grp_in, grp_out;

    if (STEPS == 1) begin : gen_full
        assign grp_in      = data_q[0];
        assign data_sub[0] = grp_out;
    end else begin : gen_iter
        assign grp_in = data_q[cnt_q];
        always_comb begin
            data_sub        = data_q;
            data_sub[cnt_q] = grp_out;
        end
    end

    // Lane j substitutes byte c*LANES + j in cycle c.
    for (genvar j = 0; j < LANES; j++) begin : gen_lane
        sbox u_sbox (
            .data_i(grp_in[8*j +: 8]),
            .data_o(grp_out[8*j +: 8])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = StSub;
                end
            end
            StSub: begin
                busy   = 1'b1;
                data_d = data_sub;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                // Taking the result frees the register in the same cycle.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d  = in_data;
                        cnt_d   = '0;
                        state_d = StSub;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: one instance per legal LANES value
// (1, 2, 4, 8, 16), driven one at a time from a single directed sequence.
// Expected results come from a table-driven S-box model via a scoreboard queue.
module tb_sub_bytes_iter;

    localparam int NDut = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [NDut];
    logic         ir   [NDut];
    logic         ordy [NDut];
    logic         ov   [NDut];
    logic         bsy  [NDut];
    logic [127:0] idat [NDut];
    logic [127:0] odat [NDut];

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDut; g++) begin : gen_dut
        sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_data  (idat[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_data (odat[g]),
            .busy     (bsy[g])
        );
    end

    // FIPS-197 S-box, row = high nibble, leftmost byte = low nibble 0.
    localparam logic [127:0] SROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = SROW[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [127:0] blk_sub(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sb(x[8*k +: 8]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Caller has in_valid high and in_ready high; this edge accepts the block.
    task automatic accept_and_time(input int d, output int lat);
        @(posedge clk);
        exp_q.push_back(blk_sub(idat[d]));
        #1;
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
        check("busy_in_sub", 128'(bsy[d]), 128'(1));
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ov[d]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic take(input int d, output logic [127:0] got);
        logic [127:0] want;
        @(negedge clk);
        ordy[d] = 1'b1;
        #1;
        check("take_valid", 128'(ov[d]), 128'(1));
        check("sb_level", 128'(exp_q.size() != 0), 128'(1));
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        got  = odat[d];
        check("take_data", odat[d], want);
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        check("valid_drop", 128'(ov[d]), 128'(0));
    endtask

    task automatic latency_block(input int d, input logic [127:0] data, output logic [127:0] got);
        int lat;
        @(negedge clk);
        iv[d]   = 1'b1;
        idat[d] = data;
        #1;
        check("idle_ready", 128'(ir[d]), 128'(1));
        accept_and_time(d, lat);
        check("latency", 128'(lat), 128'(16 >> d));
        take(d, got);
    endtask

    // Cycle-by-cycle traffic: inputs change at negedge, handshakes are decided
    // 1 time unit later and take effect at the next posedge.
    task automatic run_traffic(input int d, input int nblk, input int pv, input int pr,
                               input int budget, input bit alt, input int gap,
                               output int ntake);
        int sent;
        int last;
        bit acc;
        bit hold;
        logic [127:0] hold_dat;
        logic [127:0] want;
        sent  = 0;
        ntake = 0;
        acc   = 1'b0;
        hold  = 1'b0;
        last  = -1;
        hold_dat = '0;
        got_q.delete();
        for (int cyc = 0; cyc < budget && ntake < nblk; cyc++) begin
            @(negedge clk);
            if (acc) iv[d] = 1'b0;
            if (!iv[d] && sent < nblk && $urandom_range(99) < pv) begin
                iv[d]   = 1'b1;
                idat[d] = alt ? ((sent % 2 != 0) ? {16{8'hff}} : 128'h0)
                              : {$urandom, $urandom, $urandom, $urandom};
            end
            ordy[d] = ($urandom_range(99) < pr);
            #1;
            if (hold) begin
                check("hold_valid", 128'(ov[d]), 128'(1));
                check("hold_data", odat[d], hold_dat);
            end
            hold     = ov[d] && !ordy[d];
            hold_dat = odat[d];
            if (ov[d] && ordy[d]) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("stream_data", odat[d], want);
                got_q.push_back(odat[d]);
                if (gap > 0 && last >= 0) check("stream_gap", 128'(cyc - last), 128'(gap));
                last = cyc;
                ntake++;
            end
            acc = iv[d] && ir[d];
            if (acc) begin
                exp_q.push_back(blk_sub(idat[d]));
                sent++;
            end
        end
        @(negedge clk);
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] a_blk;
        logic [127:0] b_blk;
        int lat;
        int ntake;

        for (int d = 0; d < NDut; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            idat[d] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < NDut; d++) begin
            check("rst_out_valid", 128'(ov[d]), 128'(0));
            check("rst_in_ready", 128'(ir[d]), 128'(1));
            check("rst_busy", 128'(bsy[d]), 128'(0));
            check("rst_out_data", odat[d], 128'h0);
        end

        // Byte k = k.
        for (int d = 0; d < NDut; d++) begin
            latency_block(d, 128'h0f0e0d0c0b0a09080706050403020100, got);
            check("inc_byte0", 128'(got[7:0]), 128'(8'h63));
            check("inc_byte1", 128'(got[15:8]), 128'(8'h7c));
            check("inc_byte15", 128'(got[127:120]), 128'(8'h76));
        end

        // FIPS-197 round-1 SubBytes input/output.
        for (int d = 0; d < NDut; d++) begin
            latency_block(d, 128'h082a2bbe488de2e3f8c6f43de99aa019, got);
            check("fips", got, 128'h30e5f1ae525d981141b4bf271eb8e0d4);
        end

        // Backpressure on LANES=4 with a second block waiting.
        a_blk = {$urandom, $urandom, $urandom, $urandom};
        b_blk = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        iv[2]   = 1'b1;
        idat[2] = a_blk;
        accept_and_time(2, lat);
        check("bp_latency", 128'(lat), 128'(4));
        iv[2]   = 1'b1;
        idat[2] = b_blk;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", 128'(ir[2]), 128'(0));
            check("bp_out_valid", 128'(ov[2]), 128'(1));
            check("bp_out_data", odat[2], blk_sub(a_blk));
        end
        @(negedge clk);
        ordy[2] = 1'b1;
        #1;
        check("bp_release_ready", 128'(ir[2]), 128'(1));
        check("bp_release_data", odat[2], (exp_q.size() != 0) ? exp_q.pop_front() : 'x);
        accept_and_time(2, lat);
        check("bp_latency2", 128'(lat), 128'(4));
        take(2, got);
        check("bp_result2", got, blk_sub(b_blk));
        check("bp_no_extra", 128'(exp_q.size()), 128'(0));

        // Streaming, both handshakes held high.
        run_traffic(2, 6, 100, 100, 200, 1'b1, 5, ntake);
        check("stream_count", 128'(ntake), 128'(6));
        check("stream_first", (got_q.size() > 0) ? got_q[0] : 'x, {16{8'h63}});
        check("stream_second", (got_q.size() > 1) ? got_q[1] : 'x, {16{8'h16}});
        check("stream_sb_empty", 128'(exp_q.size()), 128'(0));

        // Reset in the middle of SUB with counter at 2.
        @(negedge clk);
        iv[2]   = 1'b1;
        idat[2] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 128'(bsy[2]), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(ov[2]), 128'(0));
        check("mid_rst_busy", 128'(bsy[2]), 128'(0));
        check("mid_rst_in_ready", 128'(ir[2]), 128'(1));
        check("mid_rst_data", odat[2], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a_blk = {$urandom, $urandom, $urandom, $urandom};
        latency_block(2, a_blk, got);
        check("post_rst_result", got, blk_sub(a_blk));

        // Random traffic on every lane count.
        for (int d = 0; d < NDut; d++) begin
            exp_q.delete();
            run_traffic(d, 200, 70, 60, 20000, 1'b0, 0, ntake);
            check("rand_count", 128'(ntake), 128'(200));
            check("rand_sb_empty", 128'(exp_q.size()), 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
